// File: rtl/trap_arbiter_pkg.sv
// rtl/trap_arbiter_pkg.sv - shared states, interrupt/cause constants and pending-mask helper for trap_arbiter
package trap_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        ACTIVE = 2'd2
    } trap_state_e;

    localparam int IRQ_MSI        = 3;
    localparam int IRQ_MTI        = 7;
    localparam int IRQ_MEI        = 11;
    localparam int IRQ_LOCAL_BASE = 16;

    localparam int MCAUSE_INT_BIT = 31;

    localparam int ECALL_M        = 11;
    localparam int ILLEGAL        = 2;
    localparam int LOAD_MISALIGN  = 4;

    // Bits of mip/mie that can ever raise a trap: the three machine
    // interrupts plus the implemented local interrupts.
    function automatic logic [31:0] pend_mask(input int num_local);
        logic [31:0] m;
        m = '0;
        m[IRQ_MSI] = 1'b1;
        m[IRQ_MTI] = 1'b1;
        m[IRQ_MEI] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < num_local) begin
                m[IRQ_LOCAL_BASE + i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - fixed-priority encoder: MEI, MSI, MTI, then local interrupts lowest index first
module trap_prio_enc
    import trap_arbiter_pkg::*;
#(
    parameter int NUM_LOCAL = 4
) (
    input  logic [31:0] i_pend,
    output logic        o_valid,
    output logic [4:0]  o_index
);

    // Later assignments override earlier ones, so the lowest-priority
    // sources are written first and MEI last.
    always_comb begin
        o_index = '0;
        for (int i = NUM_LOCAL - 1; i >= 0; i--) begin
            if (i_pend[IRQ_LOCAL_BASE + i]) begin
                o_index = 5'(IRQ_LOCAL_BASE + i);
            end
        end
        if (i_pend[IRQ_MTI]) o_index = 5'(IRQ_MTI);
        if (i_pend[IRQ_MSI]) o_index = 5'(IRQ_MSI);
        if (i_pend[IRQ_MEI]) o_index = 5'(IRQ_MEI);
        o_valid = |i_pend;
    end

endmodule

// File: rtl/trap_arbiter.sv
// rtl/trap_arbiter.sv - trap arbitration, mcause latch and flush/ack handshake; TRAP_VECTORED_EN adds trap_vector
module trap_arbiter
    import trap_arbiter_pkg::*;
#(
    parameter int NUM_LOCAL  = 4,
    parameter int EXC_CODE_W = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           mie,
    input  logic [31:0]           mip,
    input  logic                  mstatus_mie,
    input  logic [31:0]           mtvec,
    input  logic                  ex_valid,
    input  logic [EXC_CODE_W-1:0] ex_code,
    input  logic                  mret_commit,
    input  logic                  flush_ack,
    output logic                  intr_happen,
    output logic                  ex_happen,
    output logic [31:0]           trap_cause,
    output logic                  trap_flush,
    output logic                  trap_fin,
    output logic                  in_trap,
    output logic [31:0]           trap_vector
);

    localparam logic [31:0] PEND_MASK = pend_mask(NUM_LOCAL);

    trap_state_e r_state, w_state_nxt;
    logic [31:0] r_cause, w_cause_nxt;
    logic [31:0] r_vector, w_vector_nxt;
    logic        r_flush, w_flush_nxt;
    logic        r_in_trap, w_in_trap_nxt;
    logic        r_intr, w_intr_nxt;
    logic        r_ex, w_ex_nxt;
    logic        r_fin, w_fin_nxt;

    logic [31:0] w_pend;
    logic        w_irq_valid;
    logic [4:0]  w_irq_idx;
    logic [31:0] w_exc_cause;
    logic [31:0] w_int_cause;
    logic [31:0] w_vec_exc;
    logic [31:0] w_vec_int;

    assign w_pend      = mip & mie & PEND_MASK;
    assign w_exc_cause = 32'(ex_code);
    assign w_int_cause = (32'h1 << MCAUSE_INT_BIT) | 32'(w_irq_idx);

    trap_prio_enc #(
        .NUM_LOCAL (NUM_LOCAL)
    ) u_prio_enc (
        .i_pend  (w_pend),
        .o_valid (w_irq_valid),
        .o_index (w_irq_idx)
    );

`ifdef TRAP_VECTORED_EN
    logic [31:0] w_base;
    assign w_base    = {mtvec[31:2], 2'b00};
    assign w_vec_exc = w_base;
    assign w_vec_int = (mtvec[1:0] == 2'b01) ? (w_base + {25'b0, w_irq_idx, 2'b00}) : w_base;
`else
    logic w_unused_mtvec;
    assign w_unused_mtvec = ^mtvec;
    assign w_vec_exc      = '0;
    assign w_vec_int      = '0;
`endif

    // State and every output are registered together so decisions show up one edge later.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_cause   <= '0;
            r_vector  <= '0;
            r_flush   <= 1'b0;
            r_in_trap <= 1'b0;
            r_intr    <= 1'b0;
            r_ex      <= 1'b0;
            r_fin     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
            r_vector  <= w_vector_nxt;
            r_flush   <= w_flush_nxt;
            r_in_trap <= w_in_trap_nxt;
            r_intr    <= w_intr_nxt;
            r_ex      <= w_ex_nxt;
            r_fin     <= w_fin_nxt;
        end
    end

    // Next-state and next-output decisions; pulses default low, levels hold.
    always_comb begin
        w_state_nxt   = r_state;
        w_cause_nxt   = r_cause;
        w_vector_nxt  = r_vector;
        w_flush_nxt   = r_flush;
        w_in_trap_nxt = r_in_trap;
        w_intr_nxt    = 1'b0;
        w_ex_nxt      = 1'b0;
        w_fin_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (ex_valid) begin
                    w_cause_nxt  = w_exc_cause;
                    w_vector_nxt = w_vec_exc;
                    w_ex_nxt     = 1'b1;
                    w_flush_nxt  = 1'b1;
                    w_state_nxt  = FLUSH;
                end else if (mstatus_mie && w_irq_valid) begin
                    w_cause_nxt  = w_int_cause;
                    w_vector_nxt = w_vec_int;
                    w_intr_nxt   = 1'b1;
                    w_flush_nxt  = 1'b1;
                    w_state_nxt  = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_ack) begin
                    w_flush_nxt   = 1'b0;
                    w_in_trap_nxt = 1'b1;
                    w_state_nxt   = ACTIVE;
                end
            end
            ACTIVE: begin
                // A nested exception beats a same-cycle mret, which is dropped.
                if (ex_valid) begin
                    w_cause_nxt  = w_exc_cause;
                    w_vector_nxt = w_vec_exc;
                    w_ex_nxt     = 1'b1;
                    w_flush_nxt  = 1'b1;
                    w_state_nxt  = FLUSH;
                end else if (mret_commit) begin
                    w_in_trap_nxt = 1'b0;
                    w_fin_nxt     = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign intr_happen = r_intr;
    assign ex_happen   = r_ex;
    assign trap_cause  = r_cause;
    assign trap_flush  = r_flush;
    assign trap_fin    = r_fin;
    assign in_trap     = r_in_trap;
    assign trap_vector = r_vector;

endmodule

// File: tb/tb_trap_arbiter.sv
// tb/tb_trap_arbiter.sv - scoreboard bench for trap_arbiter; checks trap_vector per TRAP_VECTORED_EN
module tb_trap_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] mie, mip, mtvec;
    logic        mstatus_mie, ex_valid, mret_commit, flush_ack;
    logic [4:0]  ex_code;
    logic        intr_happen, ex_happen, trap_flush, trap_fin, in_trap;
    logic [31:0] trap_cause, trap_vector;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] EXP_VEC_MEI = 32'h0000_102C;
    localparam logic [31:0] EXP_VEC_EXC = 32'h0000_1000;
`else
    localparam logic [31:0] EXP_VEC_MEI = 32'h0;
    localparam logic [31:0] EXP_VEC_EXC = 32'h0;
`endif

    trap_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .mie         (mie),
        .mip         (mip),
        .mstatus_mie (mstatus_mie),
        .mtvec       (mtvec),
        .ex_valid    (ex_valid),
        .ex_code     (ex_code),
        .mret_commit (mret_commit),
        .flush_ack   (flush_ack),
        .intr_happen (intr_happen),
        .ex_happen   (ex_happen),
        .trap_cause  (trap_cause),
        .trap_flush  (trap_flush),
        .trap_fin    (trap_fin),
        .in_trap     (in_trap),
        .trap_vector (trap_vector)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_trap(output logic found, output logic [31:0] cause,
                             output logic intr, output logic exc, output int lat);
        found = 1'b0; cause = '0; intr = 1'b0; exc = 1'b0; lat = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (intr_happen || ex_happen) begin
                found = 1'b1; cause = trap_cause; intr = intr_happen; exc = ex_happen; lat = i;
            end
        end
    endtask

    task automatic go_active();
        flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
    endtask

    task automatic do_mret(output logic fin, output logic it);
        mret_commit = 1'b1;
        @(negedge clk);
        mret_commit = 1'b0;
        fin = trap_fin;
        it  = in_trap;
    endtask

    task automatic test_reset();
        resetn = 1'b0; mie = '0; mip = '0; mtvec = 32'h0000_1001; mstatus_mie = 1'b0;
        ex_valid = 1'b0; ex_code = '0; mret_commit = 1'b0; flush_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (trap_cause !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp 0", trap_cause); end
        checks++; if (trap_vector !== 32'h0) begin errors++; $display("FAIL reset_vector got %h exp 0", trap_vector); end
        checks++; if ({intr_happen, ex_happen, trap_flush, trap_fin, in_trap} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {intr_happen, ex_happen, trap_flush, trap_fin, in_trap});
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mei_basic();
        logic found, intr, exc, fin, it; logic [31:0] cause, exp; int lat; int fl;
        mstatus_mie = 1'b1; mie = 32'h800; mip = 32'h800;
        exp_q.push_back(32'h8000_000B);
        wait_trap(found, cause, intr, exc, lat);
        checks++; if (!(found && intr && !exc && lat == 1)) begin
            errors++; $display("FAIL mei_entry got found=%b intr=%b exc=%b lat=%0d exp 1 1 0 1", found, intr, exc, lat);
        end
        exp = exp_q.pop_front();
        checks++; if (cause !== exp) begin errors++; $display("FAIL mei_cause got %h exp %h", cause, exp); end
        checks++; if (trap_vector !== EXP_VEC_MEI) begin errors++; $display("FAIL mei_vector got %h exp %h", trap_vector, EXP_VEC_MEI); end
        fl = trap_flush ? 1 : 0;
        mip = '0;
        @(negedge clk);
        checks++; if (intr_happen !== 1'b0) begin errors++; $display("FAIL mei_pulse_width got %b exp 0", intr_happen); end
        if (trap_flush) fl++;
        @(negedge clk);
        if (trap_flush) fl++;
        flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
        checks++; if (fl != 3) begin errors++; $display("FAIL mei_flush_cycles got %0d exp 3", fl); end
        checks++; if ({trap_flush, in_trap} !== 2'b01) begin errors++; $display("FAIL mei_after_ack got %b exp 01", {trap_flush, in_trap}); end
        do_mret(fin, it);
        checks++; if ({fin, it} !== 2'b10) begin errors++; $display("FAIL mei_mret got fin,in_trap=%b exp 10", {fin, it}); end
    endtask

    task automatic test_priority();
        logic found, intr, exc, fin, it; logic [31:0] cause, exp; int lat;
        logic [31:0] clr_bits[4];
        clr_bits = '{32'h800, 32'h8, 32'h80, 32'h1_0000};
        exp_q.push_back(32'h8000_000B);
        exp_q.push_back(32'h8000_0003);
        exp_q.push_back(32'h8000_0007);
        exp_q.push_back(32'h8000_0010);
        mstatus_mie = 1'b1; mie = 32'h0001_0888; mip = 32'h0001_0888;
        for (int k = 0; k < 4; k++) begin
            wait_trap(found, cause, intr, exc, lat);
            checks++; if (!(found && intr && lat == 1)) begin
                errors++; $display("FAIL prio_take%0d got found=%b intr=%b lat=%0d exp 1 1 1", k, found, intr, lat);
            end
            exp = exp_q.pop_front();
            checks++; if (cause !== exp) begin errors++; $display("FAIL prio_cause%0d got %h exp %h", k, cause, exp); end
            mip = mip & ~clr_bits[k];
            go_active();
            do_mret(fin, it);
            checks++; if (fin !== 1'b1) begin errors++; $display("FAIL prio_fin%0d got %b exp 1", k, fin); end
        end
    endtask

    task automatic test_exc_over_intr();
        logic found, intr, exc, fin, it; logic [31:0] cause, exp; int lat;
        mstatus_mie = 1'b1; mie = 32'h80; mip = 32'h80;
        exp_q.push_back(32'h0000_000B);
        ex_valid = 1'b1; ex_code = 5'd11;
        wait_trap(found, cause, intr, exc, lat);
        ex_valid = 1'b0;
        checks++; if (!(found && exc && !intr)) begin
            errors++; $display("FAIL exc_over_intr got found=%b exc=%b intr=%b exp 1 1 0", found, exc, intr);
        end
        exp = exp_q.pop_front();
        checks++; if (cause !== exp) begin errors++; $display("FAIL exc_cause got %h exp %h", cause, exp); end
        checks++; if (trap_vector !== EXP_VEC_EXC) begin errors++; $display("FAIL exc_vector got %h exp %h", trap_vector, EXP_VEC_EXC); end
        mip = '0;
        go_active();
        do_mret(fin, it);
    endtask

    task automatic test_masking();
        logic found, intr, exc, fin, it; logic [31:0] cause, exp; int lat; int seen;
        mstatus_mie = 1'b0; mie = 32'hFFFF_FFFF; mip = 32'hFFFF_FFFF;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (intr_happen || trap_flush) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mask_global got %0d trap cycles exp 0", seen); end
        mie = 32'h800; mip = 32'h800;
        exp_q.push_back(32'h0000_0004);
        ex_valid = 1'b1; ex_code = 5'd4;
        wait_trap(found, cause, intr, exc, lat);
        ex_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (!(found && exc) || cause !== exp) begin
            errors++; $display("FAIL mask_exc got found=%b exc=%b cause=%h exp 1 1 %h", found, exc, cause, exp);
        end
        go_active();
        mstatus_mie = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (intr_happen || trap_flush) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mask_active got %0d trap cycles exp 0", seen); end
        exp_q.push_back(32'h8000_000B);
        do_mret(fin, it);
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL mask_fin got %b exp 1", fin); end
        wait_trap(found, cause, intr, exc, lat);
        exp = exp_q.pop_front();
        checks++; if (!(found && intr && lat == 1) || cause !== exp) begin
            errors++; $display("FAIL mask_retake got found=%b intr=%b lat=%0d cause=%h exp 1 1 1 %h", found, intr, lat, cause, exp);
        end
        mip = '0;
        go_active();
        do_mret(fin, it);
    endtask

    task automatic test_nested();
        logic found, intr, exc, fin, it; logic [31:0] cause, exp; int lat;
        mstatus_mie = 1'b0;
        exp_q.push_back(32'h0000_0004);
        ex_valid = 1'b1; ex_code = 5'd4;
        wait_trap(found, cause, intr, exc, lat);
        ex_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (!(found && exc) || cause !== exp) begin
            errors++; $display("FAIL nest_first got found=%b cause=%h exp 1 %h", found, cause, exp);
        end
        go_active();
        exp_q.push_back(32'h0000_0002);
        ex_valid = 1'b1; ex_code = 5'd2; mret_commit = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; mret_commit = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (trap_cause !== exp) begin errors++; $display("FAIL nest_cause got %h exp %h", trap_cause, exp); end
        checks++; if ({ex_happen, trap_fin, in_trap, trap_flush} !== 4'b1011) begin
            errors++; $display("FAIL nest_flags got ex,fin,in_trap,flush=%b exp 1011", {ex_happen, trap_fin, in_trap, trap_flush});
        end
        go_active();
        do_mret(fin, it);
        checks++; if ({fin, it} !== 2'b10) begin errors++; $display("FAIL nest_mret got %b exp 10", {fin, it}); end
    endtask

    task automatic test_reset_mid_flush();
        logic found, intr, exc; logic [31:0] cause; int lat;
        ex_valid = 1'b1; ex_code = 5'd4;
        wait_trap(found, cause, intr, exc, lat);
        ex_valid = 1'b0;
        checks++; if (trap_flush !== 1'b1) begin errors++; $display("FAIL rst_pre_flush got %b exp 1", trap_flush); end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checks++; if ({intr_happen, ex_happen, trap_flush, trap_fin, in_trap, trap_cause, trap_vector} !== 69'b0) begin
            errors++; $display("FAIL rst_mid_flush got flags=%b cause=%h vec=%h exp all 0",
                {intr_happen, ex_happen, trap_flush, trap_fin, in_trap}, trap_cause, trap_vector);
        end
        flush_ack = 1'b1; mret_commit = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0; mret_commit = 1'b0;
        checks++; if ({trap_flush, trap_fin, in_trap} !== 3'b000) begin
            errors++; $display("FAIL rst_idle_ignore got flush,fin,in_trap=%b exp 000", {trap_flush, trap_fin, in_trap});
        end
    endtask

    initial begin
        test_reset();
        test_mei_basic();
        test_priority();
        test_exc_over_intr();
        test_masking();
        test_nested();
        test_reset_mid_flush();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
